// File: rtl/src_reg_bank.sv
// Mini SRC general-purpose register bank: IR-field select/encode, BAout R0-as-zero, C sign extension,
// plus a context save/load engine. Define REGBANK_CTX_SKIP_R0_EN to leave R0 out of context transfers.
module src_reg_bank #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int OPC_W  = 5
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [DATA_W-1:0]         ir,
    input  logic                      gra,
    input  logic                      grb,
    input  logic                      grc,
    input  logic                      rin,
    input  logic                      rout,
    input  logic                      baout,
    input  logic [DATA_W-1:0]         bus_in,
    output logic [DATA_W-1:0]         bus_out,
    output logic [DATA_W-1:0]         c_sign_ext,
    input  logic                      ctx_save_req,
    input  logic                      ctx_load_req,
    output logic                      ctx_busy,
    output logic [$clog2(NREGS)-1:0]  ctx_idx,
    output logic                      ctx_wvalid,
    output logic [DATA_W-1:0]         ctx_wdata,
    input  logic                      ctx_wready,
    input  logic                      ctx_rvalid,
    input  logic [DATA_W-1:0]         ctx_rdata,
    output logic                      ctx_done
);

    localparam int IDX_W  = $clog2(NREGS);
    localparam int RA_LSB = DATA_W - OPC_W - IDX_W;
    localparam int RB_LSB = RA_LSB - IDX_W;
    localparam int RC_LSB = RB_LSB - IDX_W;
    localparam int C_W    = DATA_W - OPC_W - 2 * IDX_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);
`ifdef REGBANK_CTX_SKIP_R0_EN
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
`else
    localparam logic [IDX_W-1:0] FIRST_IDX = '0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAVE,
        ST_LOAD,
        ST_DONE
    } ctx_state_t;

    ctx_state_t        state;
    logic [DATA_W-1:0] regs [NREGS];
    logic [IDX_W-1:0]  ra, rb, rc, sel;
    logic              any_gr;
    logic              bus_we;
    logic              ctx_we;

    // The opcode bits are decoded by the control unit, not here.
    logic unused_opcode;
    assign unused_opcode = ^ir[DATA_W-1 -: OPC_W];

    assign ra     = ir[RA_LSB +: IDX_W];
    assign rb     = ir[RB_LSB +: IDX_W];
    assign rc     = ir[RC_LSB +: IDX_W];
    assign any_gr = gra | grb | grc;
    assign sel    = gra ? ra : (grb ? rb : rc);

    assign c_sign_ext = {{(DATA_W - C_W){ir[C_W-1]}}, ir[C_W-1:0]};

    assign bus_we = (state == ST_IDLE) && rin && any_gr;
    assign ctx_we = (state == ST_LOAD) && ctx_rvalid;

    // NOTE: always_comb drives a default before any branch so no path leaves bus_out unassigned (no latch).
    always_comb begin
        bus_out = '0;
        if (any_gr) begin
            if (rout || (baout && sel != '0))
                bus_out = regs[sel];
        end
    end

    assign ctx_wdata = regs[ctx_idx];

    // NOTE: the register array is clocked storage with an async clear, so every entry resets; it must
    // not be treated as a RAM macro.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (ctx_we) begin
            regs[ctx_idx] <= ctx_rdata;
        end else if (bus_we) begin
            regs[sel] <= bus_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= ST_IDLE;
            ctx_idx    <= '0;
            ctx_busy   <= 1'b0;
            ctx_wvalid <= 1'b0;
            ctx_done   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    ctx_done <= 1'b0;
                    if (ctx_save_req) begin
                        state      <= ST_SAVE;
                        ctx_idx    <= FIRST_IDX;
                        ctx_busy   <= 1'b1;
                        ctx_wvalid <= 1'b1;
                    end else if (ctx_load_req) begin
                        state    <= ST_LOAD;
                        ctx_idx  <= FIRST_IDX;
                        ctx_busy <= 1'b1;
                    end
                end
                ST_SAVE: begin
                    if (ctx_wready) begin
                        if (ctx_idx == LAST_IDX) begin
                            state      <= ST_DONE;
                            ctx_wvalid <= 1'b0;
                            ctx_done   <= 1'b1;
                        end else begin
                            ctx_idx <= ctx_idx + IDX_W'(1);
                        end
                    end
                end
                ST_LOAD: begin
                    if (ctx_rvalid) begin
                        if (ctx_idx == LAST_IDX) begin
                            state    <= ST_DONE;
                            ctx_done <= 1'b1;
                        end else begin
                            ctx_idx <= ctx_idx + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    ctx_idx  <= '0;
                    ctx_busy <= 1'b0;
                    ctx_done <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    ctx_idx    <= '0;
                    ctx_busy   <= 1'b0;
                    ctx_wvalid <= 1'b0;
                    ctx_done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_src_reg_bank.sv
// Directed self-checking bench for src_reg_bank: select/read/write, BAout, sign extension, context engine.
module tb_src_reg_bank;

    localparam int DATA_W = 32;
    localparam int NREGS  = 16;
    localparam int IDX_W  = 4;
    localparam int OPC_W  = 5;
    localparam int RA_LSB = DATA_W - OPC_W - IDX_W;
    localparam int RB_LSB = RA_LSB - IDX_W;
    localparam int RC_LSB = RB_LSB - IDX_W;
`ifdef REGBANK_CTX_SKIP_R0_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif

    logic              clk, clr;
    logic [DATA_W-1:0] ir, bus_in, bus_out, c_sign_ext, ctx_wdata, ctx_rdata;
    logic              gra, grb, grc, rin, rout, baout;
    logic              ctx_save_req, ctx_load_req, ctx_busy, ctx_wvalid, ctx_wready, ctx_rvalid, ctx_done;
    logic [IDX_W-1:0]  ctx_idx;

    int n_pass  = 0;
    int n_total = 0;
    logic [DATA_W-1:0] exp_regs [NREGS];

    src_reg_bank #(.DATA_W(DATA_W), .NREGS(NREGS), .OPC_W(OPC_W)) dut (
        .clk(clk), .clr(clr), .ir(ir), .gra(gra), .grb(grb), .grc(grc),
        .rin(rin), .rout(rout), .baout(baout), .bus_in(bus_in), .bus_out(bus_out),
        .c_sign_ext(c_sign_ext), .ctx_save_req(ctx_save_req), .ctx_load_req(ctx_load_req),
        .ctx_busy(ctx_busy), .ctx_idx(ctx_idx), .ctx_wvalid(ctx_wvalid), .ctx_wdata(ctx_wdata),
        .ctx_wready(ctx_wready), .ctx_rvalid(ctx_rvalid), .ctx_rdata(ctx_rdata), .ctx_done(ctx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input int k);
        ir = '0;
        ir[RA_LSB +: IDX_W] = k[IDX_W-1:0];
    endtask

    task automatic write_reg(input int k, input logic [DATA_W-1:0] val);
        set_ra(k);
        gra = 1'b1; rin = 1'b1; bus_in = val;
        tick();
        gra = 1'b0; rin = 1'b0;
        exp_regs[k] = val;
    endtask

    task automatic read_reg(input int k, output logic [DATA_W-1:0] val);
        set_ra(k);
        gra = 1'b1; rout = 1'b1;
        #1 val = bus_out;
        gra = 1'b0; rout = 1'b0;
    endtask

    task automatic check_all_regs(input string tag);
        logic [DATA_W-1:0] v;
        for (int k = 0; k < NREGS; k++) begin
            read_reg(k, v);
            n_total++;
            if (v !== exp_regs[k]) $display("FAIL %s r%0d: got %h expected %h", tag, k, v, exp_regs[k]);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] v;
        clr = 1'b1;
        #3;
        n_total++; if (ctx_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", ctx_busy); else n_pass++;
        n_total++; if (ctx_wvalid !== 1'b0) $display("FAIL reset_wvalid: got %b expected 0", ctx_wvalid); else n_pass++;
        n_total++; if (ctx_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", ctx_done); else n_pass++;
        n_total++; if (ctx_idx !== '0) $display("FAIL reset_idx: got %0d expected 0", ctx_idx); else n_pass++;
        for (int k = 0; k < NREGS; k++) exp_regs[k] = '0;
        read_reg(7, v);
        n_total++; if (v !== '0) $display("FAIL reset_r7: got %h expected 0", v); else n_pass++;
        #2 clr = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] v;
        ir = 32'h0120_0000;
        gra = 1'b1; rin = 1'b1; rout = 1'b1; bus_in = 32'hDEAD_BEEF;
        #1;
        n_total++; if (bus_out !== '0) $display("FAIL no_bypass: got %h expected 0", bus_out); else n_pass++;
        tick();
        rin = 1'b0;
        exp_regs[2] = 32'hDEAD_BEEF;
        n_total++; if (bus_out !== 32'hDEAD_BEEF) $display("FAIL write_read_r2: got %h expected deadbeef", bus_out); else n_pass++;
        gra = 1'b0;
        #1;
        n_total++; if (bus_out !== '0) $display("FAIL no_select_read: got %h expected 0", bus_out); else n_pass++;
        rout = 1'b0;
        rin = 1'b1; bus_in = 32'h1111_2222;
        tick();
        rin = 1'b0;
        read_reg(2, v);
        n_total++; if (v !== 32'hDEAD_BEEF) $display("FAIL no_select_write: got %h expected deadbeef", v); else n_pass++;
    endtask

    task automatic test_r0_baout();
        write_reg(0, 32'h0000_0055);
        ir = '0;
        grb = 1'b1; rout = 1'b1;
        #1;
        n_total++; if (bus_out !== 32'h55) $display("FAIL r0_rout: got %h expected 55", bus_out); else n_pass++;
        rout = 1'b0; baout = 1'b1;
        #1;
        n_total++; if (bus_out !== '0) $display("FAIL r0_baout: got %h expected 0", bus_out); else n_pass++;
        ir[RB_LSB +: IDX_W] = 4'd2;
        #1;
        n_total++; if (bus_out !== 32'hDEAD_BEEF) $display("FAIL r2_baout: got %h expected deadbeef", bus_out); else n_pass++;
        grb = 1'b0; baout = 1'b0;
        ir = 32'h0004_0000;
        #1;
        n_total++; if (c_sign_ext !== 32'hFFFC_0000) $display("FAIL c_sext_neg: got %h expected fffc0000", c_sign_ext); else n_pass++;
        ir = 32'hFFFB_FFFF;
        #1;
        n_total++; if (c_sign_ext !== 32'h0003_FFFF) $display("FAIL c_sext_pos: got %h expected 0003ffff", c_sign_ext); else n_pass++;
    endtask

    task automatic test_priority();
        write_reg(3, 32'h3333_0003);
        write_reg(4, 32'h4444_0004);
        write_reg(6, 32'h6666_0006);
        ir = '0;
        ir[RA_LSB +: IDX_W] = 4'd3;
        ir[RB_LSB +: IDX_W] = 4'd4;
        ir[RC_LSB +: IDX_W] = 4'd6;
        rout = 1'b1; gra = 1'b1; grb = 1'b1; grc = 1'b1;
        #1;
        n_total++; if (bus_out !== 32'h3333_0003) $display("FAIL prio_gra: got %h expected 33330003", bus_out); else n_pass++;
        gra = 1'b0;
        #1;
        n_total++; if (bus_out !== 32'h4444_0004) $display("FAIL prio_grb: got %h expected 44440004", bus_out); else n_pass++;
        grb = 1'b0;
        #1;
        n_total++; if (bus_out !== 32'h6666_0006) $display("FAIL prio_grc: got %h expected 66660006", bus_out); else n_pass++;
        grc = 1'b0; rout = 1'b0;
    endtask

    // Runs one save stream; both=1 also raises load_req in the request cycle.
    task automatic save_stream(input bit stall, input bit both, output int cycles, output int beats);
        int exp_idx;
        ctx_save_req = 1'b1; ctx_load_req = both; ctx_wready = 1'b0;
        tick();
        ctx_save_req = 1'b0; ctx_load_req = 1'b0;
        cycles = 0; beats = 0; exp_idx = FIRST;
        while (!ctx_done && cycles < 200) begin
            ctx_wready = stall ? cycles[0] : 1'b1;
            n_total++; if (ctx_wvalid !== 1'b1) $display("FAIL save_wvalid c%0d: got %b expected 1", cycles, ctx_wvalid); else n_pass++;
            n_total++; if (ctx_idx !== exp_idx[IDX_W-1:0]) $display("FAIL save_idx c%0d: got %0d expected %0d", cycles, ctx_idx, exp_idx); else n_pass++;
            n_total++; if (ctx_wdata !== exp_regs[exp_idx]) $display("FAIL save_wdata c%0d: got %h expected %h", cycles, ctx_wdata, exp_regs[exp_idx]); else n_pass++;
            if (ctx_wready) begin exp_idx++; beats++; end
            tick();
            cycles++;
        end
        ctx_wready = 1'b0;
        n_total++; if (ctx_done !== 1'b1) $display("FAIL save_timeout: done %b after %0d cycles", ctx_done, cycles); else n_pass++;
        tick();
        n_total++; if (ctx_done !== 1'b0 || ctx_busy !== 1'b0 || ctx_idx !== '0)
            $display("FAIL save_end: done %b busy %b idx %0d expected 0 0 0", ctx_done, ctx_busy, ctx_idx); else n_pass++;
    endtask

    task automatic test_save_full();
        int cycles, beats;
        for (int n = 0; n < NREGS; n++) write_reg(n, DATA_W'(n * 32'h1111));
        save_stream(1'b0, 1'b0, cycles, beats);
        n_total++; if (beats != NREGS - FIRST) $display("FAIL save_full_beats: got %0d expected %0d", beats, NREGS - FIRST); else n_pass++;
        n_total++; if (cycles + 1 != NREGS - FIRST + 1) $display("FAIL save_full_latency: got %0d expected %0d", cycles + 1, NREGS - FIRST + 1); else n_pass++;
    endtask

    task automatic test_save_stall();
        int cycles, beats;
        save_stream(1'b1, 1'b0, cycles, beats);
        n_total++; if (beats != NREGS - FIRST) $display("FAIL save_stall_beats: got %0d expected %0d", beats, NREGS - FIRST); else n_pass++;
        n_total++; if (cycles != 2 * (NREGS - FIRST)) $display("FAIL save_stall_cycles: got %0d expected %0d", cycles, 2 * (NREGS - FIRST)); else n_pass++;
    endtask

    task automatic test_load();
        int k, cycles;
        ctx_load_req = 1'b1;
        tick();
        ctx_load_req = 1'b0;
        set_ra(5); gra = 1'b1; rin = 1'b1; bus_in = 32'h1234_5678;
        k = FIRST; cycles = 0;
        while (!ctx_done && cycles < 200) begin
            ctx_rvalid   = (cycles % 3 != 1);
            ctx_rdata    = ctx_rvalid ? 32'hA000_0000 + DATA_W'(k) : 32'hBAD0_BAD0;
            ctx_save_req = (cycles == 4);
            n_total++; if (ctx_wvalid !== 1'b0 || ctx_busy !== 1'b1)
                $display("FAIL load_flags c%0d: wvalid %b busy %b expected 0 1", cycles, ctx_wvalid, ctx_busy); else n_pass++;
            n_total++; if (ctx_idx !== k[IDX_W-1:0]) $display("FAIL load_idx c%0d: got %0d expected %0d", cycles, ctx_idx, k); else n_pass++;
            if (ctx_rvalid) begin exp_regs[k] = 32'hA000_0000 + DATA_W'(k); k++; end
            tick();
            cycles++;
        end
        ctx_rvalid = 1'b0; ctx_save_req = 1'b0; rin = 1'b0; gra = 1'b0;
        n_total++; if (ctx_done !== 1'b1) $display("FAIL load_timeout: done %b after %0d cycles", ctx_done, cycles); else n_pass++;
        n_total++; if (k != NREGS) $display("FAIL load_beats: got %0d expected %0d", k - FIRST, NREGS - FIRST); else n_pass++;
        tick();
        n_total++; if (ctx_done !== 1'b0 || ctx_busy !== 1'b0) $display("FAIL load_end: done %b busy %b expected 0 0", ctx_done, ctx_busy); else n_pass++;
        tick();
        n_total++; if (ctx_busy !== 1'b0 || ctx_wvalid !== 1'b0) $display("FAIL busy_req_queued: busy %b wvalid %b expected 0 0", ctx_busy, ctx_wvalid); else n_pass++;
        check_all_regs("load");
    endtask

    task automatic test_both_req();
        int cycles, beats;
        save_stream(1'b0, 1'b1, cycles, beats);
        n_total++; if (beats != NREGS - FIRST) $display("FAIL both_beats: got %0d expected %0d", beats, NREGS - FIRST); else n_pass++;
        check_all_regs("both_req");
    endtask

    task automatic test_clr_mid();
        bit seen_done;
        logic [DATA_W-1:0] v;
        ctx_save_req = 1'b1; ctx_wready = 1'b1;
        tick();
        ctx_save_req = 1'b0;
        repeat (5) tick();
        #2 clr = 1'b1;
        #1;
        n_total++; if (ctx_busy !== 1'b0 || ctx_wvalid !== 1'b0 || ctx_done !== 1'b0 || ctx_idx !== '0)
            $display("FAIL clr_mid_flags: busy %b wvalid %b done %b idx %0d expected 0", ctx_busy, ctx_wvalid, ctx_done, ctx_idx); else n_pass++;
        read_reg(10, v);
        n_total++; if (v !== '0) $display("FAIL clr_mid_r10: got %h expected 0", v); else n_pass++;
        #1 clr = 1'b0;
        seen_done = 1'b0;
        repeat (20) begin
            tick();
            if (ctx_done || ctx_busy) seen_done = 1'b1;
        end
        ctx_wready = 1'b0;
        n_total++; if (seen_done !== 1'b0) $display("FAIL clr_mid_resume: got activity %b expected 0", seen_done); else n_pass++;
        for (int k = 0; k < NREGS; k++) exp_regs[k] = '0;
        check_all_regs("clr_mid");
    endtask

    initial begin
        ir = '0; bus_in = '0; ctx_rdata = '0;
        gra = 0; grb = 0; grc = 0; rin = 0; rout = 0; baout = 0;
        ctx_save_req = 0; ctx_load_req = 0; ctx_wready = 0; ctx_rvalid = 0;
        clr = 1'b0;
        #1;
        test_reset();
        test_write_read();
        test_r0_baout();
        test_priority();
        test_save_full();
        test_save_stall();
        test_load();
        test_both_req();
        test_clr_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
